// File: rtl/sfifo_wr_arbiter_pkg.sv
// Shared types and the round-robin selection function for the FIFO write-port arbiter.
package sfifo_wr_arbiter_pkg;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned MAX_IW   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic              found;
        logic [MAX_IW-1:0] idx;
    } pick_t;

    // Lowest valid index above last wins; otherwise wrap to the lowest valid index overall.
    function automatic pick_t rr_pick_fn(
        input logic [MAX_NREQ-1:0] valid,
        input logic [MAX_IW-1:0]   last,
        input int unsigned         nreq
    );
        pick_t hi;
        pick_t lo;
        hi = '0;
        lo = '0;
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (i < int'(nreq) && valid[i]) begin
                lo.found = 1'b1;
                lo.idx   = MAX_IW'(i);
                if (i > int'(last)) begin
                    hi.found = 1'b1;
                    hi.idx   = MAX_IW'(i);
                end
            end
        end
        return hi.found ? hi : lo;
    endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_rr_pick.sv
// Combinational next-owner selector: scans requesters starting just after last.
module sfifo_wr_arbiter_rr_pick
    import sfifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   idx,
    output logic            found
);

    pick_t pick;

    assign pick  = rr_pick_fn(MAX_NREQ'(valid), MAX_IW'(last), NREQ);
    assign idx   = IW'(pick.idx);
    assign found = pick.found;

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one synchronous FIFO write port among NREQ producers.
module sfifo_wr_arbiter
    import sfifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_wfull,
    output logic                  fifo_winc,
    output logic [WIDTH-1:0]      fifo_wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int unsigned    IW        = $clog2(NREQ);
    localparam int unsigned    CW        = $clog2(BURST) + 1;
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST - 1);

    state_t          state;
    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   grant_idx;
    logic [CW-1:0]   beat_cnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic            owner_valid;
    logic [WIDTH-1:0] owner_data;
    logic [NREQ-1:0] owner_oh;
    logic            in_grant;
    logic            xfer;
    logic            rel;

    sfifo_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid (req_valid),
        .last  (last_idx),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Mux the current owner's channel onto the write port.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        owner_oh    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_idx == IW'(i)) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*WIDTH +: WIDTH];
                owner_oh[i] = 1'b1;
            end
        end
    end

    // A reset cycle suppresses any write even if the state register still shows GRANT.
    assign in_grant   = (state == GRANT) && rst_n;
    assign xfer       = in_grant && owner_valid && !fifo_wfull;
    assign rel        = in_grant && ((xfer && beat_cnt == LAST_BEAT) || !owner_valid);
    assign req_ready  = (in_grant && !fifo_wfull) ? owner_oh : '0;
    assign fifo_winc  = xfer;
    assign fifo_wdata = xfer ? owner_data : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_idx  <= IW'(NREQ - 1);
            grant_idx <= '0;
            beat_cnt  <= '0;
            grant     <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        grant_idx <= pick_idx;
                        beat_cnt  <= '0;
                        grant     <= NREQ'(1) << pick_idx;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state    <= IDLE;
                        last_idx <= grant_idx;
                        beat_cnt <= '0;
                        grant    <= '0;
                        busy     <= 1'b0;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Directed and random bench for sfifo_wr_arbiter with producer models and a write scoreboard.
module tb_sfifo_wr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned BURST = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wfull;
    logic                  fifo_winc;
    logic [WIDTH-1:0]      fifo_wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    sfifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [WIDTH-1:0] wlog[$];
    int seq[NREQ];
    int sb_seq[NREQ];
    int sb_err;
    int winc_full;
    int wait_cnt[NREQ];
    int wait_max[NREQ];
    logic s_winc;
    logic [NREQ-1:0] s_ready;

    function automatic logic [WIDTH-1:0] pat(input int i, input int s);
        return WIDTH'((i + 1) * 16 + s + 1);
    endfunction

    // One clock: sample pre-edge, then advance producers that had a beat accepted.
    task automatic tick();
        logic [NREQ-1:0] acc;
        int gi;
        int n;
        #1;
        s_winc  = fifo_winc;
        s_ready = req_ready;
        acc     = req_valid & req_ready;
        if (fifo_winc && fifo_wfull) winc_full++;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) wait_cnt[i] = 0;
            else if (req_valid[i] && !fifo_wfull) begin
                wait_cnt[i]++;
                if (wait_cnt[i] > wait_max[i]) wait_max[i] = wait_cnt[i];
            end
        end
        if (fifo_winc) begin
            wlog.push_back(fifo_wdata);
            gi = -1;
            n  = 0;
            for (int i = 0; i < NREQ; i++) if (grant[i]) begin gi = i; n++; end
            if (n != 1) sb_err++;
            else if (fifo_wdata !== pat(gi, sb_seq[gi])) sb_err++;
            else sb_seq[gi]++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                seq[i]++;
                req_data[i*WIDTH +: WIDTH] = pat(i, seq[i]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        fifo_wfull = 1'b0;
        tick();
        rst_n = 1'b1;
        wlog.delete();
        sb_err    = 0;
        winc_full = 0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]      = 0;
            sb_seq[i]   = 0;
            wait_cnt[i] = 0;
            wait_max[i] = 0;
            req_data[i*WIDTH +: WIDTH] = pat(i, 0);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        checks++; if (s_winc !== 1'b0) begin errors++; $display("FAIL rst_winc: got %b expected 0", s_winc); end
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", s_ready); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        #1;
        checks++; if (fifo_wdata !== 8'h00 || fifo_winc !== 1'b0) begin errors++; $display("FAIL rst_wport: got winc=%b wdata=%h expected 0/00", fifo_winc, fifo_wdata); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_first_winner: got %b expected 0001", grant); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        tick();
        checks++; if (s_winc !== 1'b0) begin errors++; $display("FAIL single_idle_winc: got %b expected 0", s_winc); end
        checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single_grant: got %b/%b expected 0001/1", grant, busy); end
        for (int b = 0; b < 4; b++) begin
            tick();
            checks++; if (s_winc !== 1'b1 || s_ready !== 4'b0001) begin errors++; $display("FAIL single_beat%0d: got winc=%b ready=%b expected 1/0001", b, s_winc, s_ready); end
        end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got %b/%b expected 0000/0", grant, busy); end
        checks++; if (wlog.size() != 4) begin errors++; $display("FAIL single_count: got %0d expected 4", wlog.size()); end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            checks++; if (wlog[k] !== pat(0, k)) begin errors++; $display("FAIL single_data%0d: got %h expected %h", k, wlog[k], pat(0, k)); end
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] exp_g;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 20; c++) begin
            exp_g = (c % 5 == 4) ? 4'b0000 : 4'(1 << (c / 5));
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant_c%0d: got %b expected %b", c, grant, exp_g); end
            tick();
        end
        checks++; if (wlog.size() != 16) begin errors++; $display("FAIL rr_count: got %0d expected 16", wlog.size()); end
        for (int k = 0; k < 16 && k < wlog.size(); k++) begin
            exp_d = pat(k / 4, k % 4);
            checks++; if (wlog[k] !== exp_d) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", k, wlog[k], exp_d); end
        end
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rr_wrap: got %b expected 0001", grant); end
        req_valid = '0;
    endtask

    task automatic test_drop();
        do_reset();
        req_valid = 4'b1100;
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL drop_grant2: got %b expected 0100", grant); end
        tick();
        tick();
        req_valid = 4'b1000;
        tick();
        checks++; if (s_winc !== 1'b0) begin errors++; $display("FAIL drop_nowrite: got %b expected 0", s_winc); end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL drop_release: got %b/%b expected 0000/0", grant, busy); end
        tick();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_next3: got %b expected 1000", grant); end
        checks++; if (wlog.size() != 2) begin errors++; $display("FAIL drop_count: got %0d expected 2", wlog.size()); end
        else begin
            checks++; if (wlog[0] !== 8'h31 || wlog[1] !== 8'h32) begin errors++; $display("FAIL drop_data: got %h %h expected 31 32", wlog[0], wlog[1]); end
        end
        req_valid = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0001;
        tick();
        tick();
        fifo_wfull = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++; if (s_winc !== 1'b0 || s_ready !== 4'b0000) begin errors++; $display("FAIL stall%0d: got winc=%b ready=%b expected 0/0000", s, s_winc, s_ready); end
            checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL stall_hold%0d: got %b expected 0001", s, grant); end
        end
        fifo_wfull = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_release: got %b expected 0000", grant); end
        checks++; if (wlog.size() != 4) begin errors++; $display("FAIL stall_count: got %0d expected 4", wlog.size()); end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            checks++; if (wlog[k] !== pat(0, k)) begin errors++; $display("FAIL stall_data%0d: got %h expected %h", k, wlog[k], pat(0, k)); end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL midrst_grant1: got %b expected 0010", grant); end
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (s_winc !== 1'b0) begin errors++; $display("FAIL midrst_nowrite: got %b expected 0", s_winc); end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state: got %b/%b expected 0000/0", grant, busy); end
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++; if (fifo_winc !== 1'b0) begin errors++; $display("FAIL midrst_winc: got %b expected 0", fifo_winc); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_winner: got %b expected 0001", grant); end
        checks++; if (wlog.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d expected 2", wlog.size()); end
        req_valid = '0;
    endtask

    task automatic test_random();
        int total;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) req_valid[i] = ($urandom_range(2) == 0);
                else if (grant[i]) req_valid[i] = ($urandom_range(5) != 0);
            end
            fifo_wfull = ($urandom_range(3) == 0);
            tick();
        end
        checks++; if (sb_err !== 0) begin errors++; $display("FAIL rand_order: got %0d bad writes expected 0", sb_err); end
        checks++; if (winc_full !== 0) begin errors++; $display("FAIL rand_winc_full: got %0d expected 0", winc_full); end
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            total += sb_seq[i];
            checks++; if (wait_max[i] > NREQ * (BURST + 1)) begin errors++; $display("FAIL rand_wait%0d: got %0d expected <= %0d", i, wait_max[i], NREQ * (BURST + 1)); end
            checks++; if (seq[i] != sb_seq[i]) begin errors++; $display("FAIL rand_accept%0d: accepted %0d written %0d", i, seq[i], sb_seq[i]); end
        end
        checks++; if (total < 1000) begin errors++; $display("FAIL rand_throughput: got %0d writes expected >= 1000", total); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        fifo_wfull = 1'b0;
        sb_err     = 0;
        winc_full  = 0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]      = 0;
            sb_seq[i]   = 0;
            wait_cnt[i] = 0;
            wait_max[i] = 0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_full_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sfifo_wr_arbiter.md
Name: sfifo_wr_arbiter

Overview:
Round-robin write arbiter that lets NREQ producers share the single write port of one synchronous FIFO (clk/rst_n, winc/wdata/wfull interface).
Grants one requester at a time for a burst of up to BURST beats, then rotates priority.
Sits between producer channels and the FIFO write side; the FIFO read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width per beat, equals the FIFO WIDTH
BURST, 4, maximum beats per grant before forced rotation (1..16)

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  reset, synchronous, active-low (one clock; polarity and synchronicity fixed)
req_valid  input  NREQ  per-requester data-valid
req_data  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot-or-zero; beat accepted from i when req_valid[i] & req_ready[i]
fifo_wfull  input  1  FIFO full flag
fifo_winc  output  1  FIFO write enable
fifo_wdata  output  WIDTH  FIFO write data
grant  output  NREQ  registered one-hot of current owner; zero when idle
busy  output  1  high in GRANT state

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, last_idx=NREQ-1 (requester 0 wins first), grant_idx=0, beat_cnt=0.
- Reset effect on outputs: grant=0, busy=0, req_ready=0, fifo_winc=0, fifo_wdata=0.
- Reset mid-burst aborts the grant with no write that cycle.
- States: IDLE, GRANT.
- IDLE: if any req_valid, next owner = first i with req_valid[i], scanning last_idx+1, last_idx+2, ... mod NREQ.
  - Register the owner into grant_idx; go to GRANT; beat_cnt=0.
  - Arbitration latency is 1 cycle; no transfer happens in IDLE.
- GRANT, owner g:
  - xfer = req_valid[g] & ~fifo_wfull.
  - req_ready[g] = ~fifo_wfull; all other req_ready bits are 0.
  - fifo_winc = xfer; fifo_wdata = req_data[g] when xfer, else 0. Both combinational from registered state and inputs.
- Release to IDLE with last_idx<=g, beat_cnt<=0 when either:
  (a) xfer and beat_cnt==BURST-1, or
  (b) ~req_valid[g] (owner dropped valid; no transfer that cycle).
- Otherwise, on xfer, beat_cnt<=beat_cnt+1.
- fifo_wfull high stalls: no transfer, no count, grant held, no timeout.
- Back-to-back bursts: after release there is always one IDLE cycle (1 bubble) before the next grant, including when the same requester re-wins.
- Fairness: a continuously requesting channel waits at most (NREQ-1) bursts plus NREQ bubbles (ignoring full stalls).
- fifo_winc is never asserted while fifo_wfull=1. The arbiter adds no buffering, so no data is dropped or duplicated.
- beat_cnt width is clog2(BURST)+1; it never exceeds BURST-1.
- Requester input changes during GRANT for non-owners are ignored until the next IDLE.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1).
- Shared package: round-robin pick function (mask above last_idx, priority-find, fall back to unmasked priority-find).
- One sub-module is natural: rr_pick (combinational next-owner selector, inputs req_valid and last_idx, outputs idx and found).
- Pair with the existing synchronous FIFO in integration benches; no RAM is instantiated here.

Test Plan:
- Reset, req_valid=4'b0001, data 0x11..0x14, fifo_wfull=0:
  -> grant=0001 one cycle after valid.
  -> fifo_winc high 4 consecutive cycles writing 0x11,0x12,0x13,0x14.
  -> returns to IDLE.
- All four requesters valid continuously, BURST=4:
  -> grant order 0,1,2,3,0 with 4 writes each and exactly 1 idle cycle between bursts.
  -> 16 writes total in 20 cycles after the first grant.
- Owner 2 drops req_valid after 2 beats:
  -> release after 2 writes; next grant goes to 3 (if valid), not back to 2.
- fifo_wfull asserted for 3 cycles mid-burst at beat 1:
  -> fifo_winc=0 and req_ready=0 for those cycles; grant held.
  -> burst completes with exactly 4 total writes, in order.
- Reset (rst_n=0 for 1 cycle) during beat 2 of a burst for requester 1:
  -> next cycle grant=0, busy=0, fifo_winc=0.
  -> with all valid afterwards, requester 0 wins first.
- Random valid/full stimulus for 10k cycles:
  -> scoreboard per-requester data order preserved.
  -> fifo_winc never high with fifo_wfull.
  -> each requester's wait is at most NREQ*(BURST+1) non-full cycles.
